// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP TX frame arbiter: FSM state encoding and source ids.
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  localparam logic SRC_IMG = 1'b0;
  localparam logic SRC_CMD = 1'b1;

endpackage

// File: rtl/udp_tx_arbiter.sv
// Frame-locked arbiter sharing one UDP TX application port between an image streamer (s0) and a
// command sender (s1). Optional no-progress watchdog is enabled by defining UDP_ARB_TIMEOUT_EN.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int IFG_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int HI_PRIO_SRC = 1
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        s0_tx_req,
  input  logic [15:0] s0_tx_length,
  input  logic        s0_tx_valid,
  input  logic [7:0]  s0_tx_data,
  output logic        s0_grant,
  output logic        s0_tx_ack,
  output logic        s0_done,
  input  logic        s1_tx_req,
  input  logic [15:0] s1_tx_length,
  input  logic        s1_tx_valid,
  input  logic [7:0]  s1_tx_data,
  output logic        s1_grant,
  output logic        s1_tx_ack,
  output logic        s1_done,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        arb_busy,
  output logic        arb_abort
);

`ifdef UDP_ARB_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam int   GAP_W  = $clog2(IFG_CYCLES + 1);
  localparam int   WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic HI_SRC = (HI_PRIO_SRC != 0) ? 1'b1 : 1'b0;

  arb_state_t        state;
  logic              src;
  logic              last_src;
  logic [15:0]       byte_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WD_W-1:0]   wd_cnt;

  logic s0_ok, s1_ok, win;
  logic sel_req, sel_valid;
  logic [7:0] sel_data;
  logic in_frame, wd_kick, wd_fire, last_beat;

  // Source selection and payload mux; the ungranted source never reaches the UDP port
  assign sel_req   = src ? s1_tx_req   : s0_tx_req;
  assign sel_valid = src ? s1_tx_valid : s0_tx_valid;
  assign sel_data  = src ? s1_tx_data  : s0_tx_data;

  assign s0_ok = s0_tx_req && (s0_tx_length != 16'd0);
  assign s1_ok = s1_tx_req && (s1_tx_length != 16'd0);
  // Contested: high-priority source wins unless it took the previous grant
  assign win   = (s0_ok && s1_ok) ? ((last_src == HI_SRC) ? ~HI_SRC : HI_SRC) : s1_ok;

  assign in_frame  = (state == ST_REQ) || (state == ST_XFER);
  assign wd_kick   = !in_frame || ((state == ST_REQ) && app_tx_ack) ||
                     ((state == ST_XFER) && sel_valid);
  assign wd_fire   = WD_EN && !wd_kick && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign last_beat = sel_valid && ((byte_cnt + 16'd1) == udp_data_length);

  assign app_tx_data_request = (state == ST_REQ) && udp_tx_ready;
  assign s0_tx_ack           = (state == ST_REQ) && (src == SRC_IMG) && sel_req && app_tx_ack;
  assign s1_tx_ack           = (state == ST_REQ) && (src == SRC_CMD) && sel_req && app_tx_ack;
  assign app_tx_data_valid   = (state == ST_XFER) && sel_valid;
  assign app_tx_data         = (state == ST_XFER) ? sel_data : 8'h00;
  assign arb_busy            = (state != ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      src             <= SRC_IMG;
      last_src        <= SRC_IMG;
      byte_cnt        <= '0;
      gap_cnt         <= '0;
      wd_cnt          <= '0;
      udp_data_length <= '0;
      s0_grant        <= 1'b0;
      s1_grant        <= 1'b0;
      s0_done         <= 1'b0;
      s1_done         <= 1'b0;
      arb_abort       <= 1'b0;
    end else begin
      s0_done   <= 1'b0;
      s1_done   <= 1'b0;
      arb_abort <= 1'b0;
      wd_cnt    <= wd_kick ? '0 : wd_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          gap_cnt  <= '0;
          // Zero-length requests are acknowledged with done only, never granted
          if (s0_tx_req && (s0_tx_length == 16'd0) && !s0_done) s0_done <= 1'b1;
          if (s1_tx_req && (s1_tx_length == 16'd0) && !s1_done) s1_done <= 1'b1;
          if (s0_ok || s1_ok) begin
            state           <= ST_REQ;
            src             <= win;
            last_src        <= win;
            udp_data_length <= win ? s1_tx_length : s0_tx_length;
            s0_grant        <= ~win;
            s1_grant        <= win;
          end
        end

        ST_REQ: begin
          if (!sel_req) begin
            state    <= ST_IDLE;
            s0_grant <= 1'b0;
            s1_grant <= 1'b0;
          end else if (app_tx_ack) begin
            state    <= ST_XFER;
            byte_cnt <= '0;
          end else if (wd_fire) begin
            state     <= ST_GAP;
            arb_abort <= 1'b1;
            s0_done   <= ~src;
            s1_done   <= src;
            s0_grant  <= 1'b0;
            s1_grant  <= 1'b0;
          end
        end

        ST_XFER: begin
          if (last_beat || wd_fire) begin
            state     <= ST_GAP;
            arb_abort <= wd_fire;
            s0_done   <= ~src;
            s1_done   <= src;
            s0_grant  <= 1'b0;
            s1_grant  <= 1'b0;
          end else if (sel_valid) begin
            byte_cnt <= byte_cnt + 16'd1;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: single frame, arbitration/alternation, deferral, zero length, reset.
module tb_udp_tx_arbiter;

  localparam int IFG = 16;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        s0_tx_req, s0_tx_valid, s0_grant, s0_tx_ack, s0_done;
  logic [15:0] s0_tx_length;
  logic [7:0]  s0_tx_data;
  logic        s1_tx_req, s1_tx_valid, s1_grant, s1_tx_ack, s1_done;
  logic [15:0] s1_tx_length;
  logic [7:0]  s1_tx_data;
  logic        udp_tx_ready, app_tx_ack, app_tx_data_request, app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;
  logic        arb_busy, arb_abort;

  int n_tests = 0;
  int n_fail  = 0;

  udp_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYC(4096), .HI_PRIO_SRC(1)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .s0_tx_req(s0_tx_req), .s0_tx_length(s0_tx_length), .s0_tx_valid(s0_tx_valid),
    .s0_tx_data(s0_tx_data), .s0_grant(s0_grant), .s0_tx_ack(s0_tx_ack), .s0_done(s0_done),
    .s1_tx_req(s1_tx_req), .s1_tx_length(s1_tx_length), .s1_tx_valid(s1_tx_valid),
    .s1_tx_data(s1_tx_data), .s1_grant(s1_grant), .s1_tx_ack(s1_tx_ack), .s1_done(s1_done),
    .udp_tx_ready(udp_tx_ready), .app_tx_ack(app_tx_ack),
    .app_tx_data_request(app_tx_data_request), .app_tx_data_valid(app_tx_data_valid),
    .app_tx_data(app_tx_data), .udp_data_length(udp_data_length),
    .arb_busy(arb_busy), .arb_abort(arb_abort)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic r, input logic [15:0] len);
    if (s == 0) begin s0_tx_req = r; s0_tx_length = len; end
    else        begin s1_tx_req = r; s1_tx_length = len; end
  endtask

  task automatic set_beat(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin s0_tx_valid = v; s0_tx_data = d; end
    else        begin s1_tx_valid = v; s1_tx_data = d; end
  endtask

  function automatic logic grant_of(input int s);
    return (s == 0) ? s0_grant : s1_grant;
  endfunction

  function automatic logic done_of(input int s);
    return (s == 0) ? s0_done : s1_done;
  endfunction

  task automatic wait_grant(input int s, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (grant_of(s)) break;
      tick();
    end
    chk($sformatf("grant_s%0d", s), grant_of(s), 1'b1);
    chk($sformatf("other_grant_s%0d", 1 - s), grant_of(1 - s), 1'b0);
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (!arb_busy) break;
      tick();
    end
    chk("idle", arb_busy, 1'b0);
  endtask

  // Called with the source granted and the FSM in REQ; acks, streams len bytes, checks done
  task automatic do_frame(input int s, input int len, input logic [7:0] base);
    logic [7:0] b;
    app_tx_ack = 1'b1;
    #1;
    chk($sformatf("ack_fwd_s%0d", s), (s == 0) ? s0_tx_ack : s1_tx_ack, 1'b1);
    chk($sformatf("ack_blk_s%0d", 1 - s), (s == 0) ? s1_tx_ack : s0_tx_ack, 1'b0);
    tick();
    app_tx_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      set_beat(s, 1'b1, b);
      #1;
      chk("beat_valid", app_tx_data_valid, 1'b1);
      chk("beat_data", app_tx_data, b);
      chk("beat_nodone", done_of(s), 1'b0);
      tick();
    end
    set_beat(s, 1'b0, 8'h00);
    chk($sformatf("done_s%0d", s), done_of(s), 1'b1);
    chk($sformatf("grant_rel_s%0d", s), grant_of(s), 1'b0);
    set_req(s, 1'b0, 16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_g0"}, s0_grant, 1'b0);
    chk({tag, "_g1"}, s1_grant, 1'b0);
    chk({tag, "_d0"}, s0_done, 1'b0);
    chk({tag, "_d1"}, s1_done, 1'b0);
    chk({tag, "_busy"}, arb_busy, 1'b0);
    chk({tag, "_dreq"}, app_tx_data_request, 1'b0);
    chk({tag, "_dval"}, app_tx_data_valid, 1'b0);
    chk({tag, "_data"}, app_tx_data, 8'h00);
    chk({tag, "_len"}, udp_data_length, 16'h0000);
    chk({tag, "_abort"}, arb_abort, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 16'd0); set_req(1, 1'b0, 16'd0);
    set_beat(0, 1'b0, 8'h00); set_beat(1, 1'b0, 8'h00);
    udp_tx_ready = 1'b1; app_tx_ack = 1'b0;
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Single s0 frame of 4 bytes, ack on the third cycle
    set_req(0, 1'b1, 16'd4);
    tick();
    chk("t1_grant", s0_grant, 1'b1);
    chk("t1_len", udp_data_length, 16'd4);
    chk("t1_busy", arb_busy, 1'b1);
    chk("t1_dreq", app_tx_data_request, 1'b1);
    udp_tx_ready = 1'b0;
    #1;
    chk("t1_dreq_notready", app_tx_data_request, 1'b0);
    tick();
    udp_tx_ready = 1'b1;
    do_frame(0, 4, 8'hA1);
    chk("t1_busy_gap", arb_busy, 1'b1);
    tick();
    chk("t1_done_pulse", s0_done, 1'b0);
    repeat (IFG - 2) tick();
    chk("t1_busy_ifg_end", arb_busy, 1'b1);
    tick();
    chk("t1_idle", arb_busy, 1'b0);

    // Contested start: s1 wins, then alternation hands the next contested round to s0
    set_req(0, 1'b1, 16'd2);
    set_req(1, 1'b1, 16'd3);
    tick();
    chk("t2_s1_first", s1_grant, 1'b1);
    chk("t2_s0_wait", s0_grant, 1'b0);
    chk("t2_len", udp_data_length, 16'd3);
    do_frame(1, 3, 8'hB0);
    set_req(1, 1'b1, 16'd3);
    wait_grant(0, IFG + 4);
    chk("t2_len_s0", udp_data_length, 16'd2);
    do_frame(0, 2, 8'hC0);
    set_req(0, 1'b1, 16'd2);
    wait_grant(1, IFG + 4);
    do_frame(1, 3, 8'hB8);
    set_req(0, 1'b0, 16'd0);
    wait_idle(IFG + 4);

    // s1 asks while s0 streams; its noise beats must stay off the UDP port
    set_req(0, 1'b1, 16'd3);
    tick();
    chk("t3_s0_grant", s0_grant, 1'b1);
    set_req(1, 1'b1, 16'd2);
    set_beat(1, 1'b1, 8'h55);
    do_frame(0, 3, 8'hD0);
    for (int k = 1; k <= IFG; k++) begin
      tick();
      chk("t3_s1_deferred", s1_grant, 1'b0);
    end
    tick();
    chk("t3_s1_grant", s1_grant, 1'b1);
    set_beat(1, 1'b0, 8'h00);
    do_frame(1, 2, 8'hE0);
    wait_idle(IFG + 4);

    // Zero-length request: done only, no UDP request
    set_req(0, 1'b1, 16'd0);
    #1;
    chk("t4_dreq_pre", app_tx_data_request, 1'b0);
    tick();
    chk("t4_done", s0_done, 1'b1);
    chk("t4_nogrant", s0_grant, 1'b0);
    chk("t4_notbusy", arb_busy, 1'b0);
    chk("t4_dreq", app_tx_data_request, 1'b0);
    set_req(0, 1'b0, 16'd0);
    tick();
    chk("t4_done_end", s0_done, 1'b0);

    // Request withdrawn while waiting for the UDP ack
    set_req(0, 1'b1, 16'd5);
    tick();
    chk("t5_grant", s0_grant, 1'b1);
    set_req(0, 1'b0, 16'd0);
    tick();
    chk("t5_released", s0_grant, 1'b0);
    chk("t5_idle", arb_busy, 1'b0);
    chk("t5_nodone", s0_done, 1'b0);

    // Reset on beat 2 of 8, then a fresh frame
    set_req(0, 1'b1, 16'd8);
    tick();
    app_tx_ack = 1'b1;
    tick();
    app_tx_ack = 1'b0;
    set_beat(0, 1'b1, 8'h11);
    tick();
    set_beat(0, 1'b1, 8'h12);
    rst_n = 1'b0;
    tick();
    chk_all_zero("t6_rst");
    rst_n = 1'b1;
    set_req(0, 1'b0, 16'd0);
    set_beat(0, 1'b0, 8'h00);
    tick();
    set_req(0, 1'b1, 16'd2);
    tick();
    chk("t6_regrant", s0_grant, 1'b1);
    chk("t6_len", udp_data_length, 16'd2);
    do_frame(0, 2, 8'hF0);
    wait_idle(IFG + 4);
    chk("t6_abort", arb_abort, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
